ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- Input-side counterpart to the board display/LED output path.
- Receives device-to-host PS/2 keyboard frames from the board PS/2 pins.
- Checks framing and odd parity, then buffers 8-bit scan codes in a small FIFO.
- Presents scan codes to downstream logic (operand/func entry for the ALU datapath) over a valid/ready interface.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 5000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from pin, asynchronous to clk, idles high.
- ps2_data  input  1  raw PS/2 data from pin, asynchronous to clk, idles high.
- code  output  8  scan code at FIFO head; meaningful only while valid=1.
- valid  output  1  FIFO non-empty.
- ready  input  1  consumer accepts code when valid&&ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of overflow.
- frame_err  output  1  one-cycle pulse on a bad start, stop or parity bit, or on timeout.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - all outputs to 0 (valid=0, fifo_count=0, overflow=0, frame_err=0, code=0);
  - FIFO pointers to 0;
  - bit counter and timeout counter to 0;
  - synchronizer and edge-detect flops to 1 (idle level), so release of reset never creates a false edge.
- Input synchronization:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - A third flop on the synced clock provides edge detection.
  - Falling edge = prev=1 && curr=0. The synced ps2_data is sampled in that same cycle.
- Frame: 11 bits, LSB first. Bit 0 is start (must be 0), bits 1-8 are data, bit 9 is odd parity, bit 10 is stop (must be 1).
- Bit counter runs 0..10 and advances one per falling edge.
- On the stop-bit edge, the counter returns to 0 and the frame is checked:
  - good if start==0, stop==1, and XOR(data[7:0],parity)==1;
  - a good frame produces a push request in the next cycle, so code/valid update 2 clk cycles after the stop-bit edge is detected;
  - a bad frame produces frame_err=1 for exactly 1 cycle, with no push.
- Timeout:
  - The idle counter clears on every falling edge and counts while bit counter != 0.
  - At TIMEOUT_CYCLES-1 it aborts the frame: bit counter = 0, frame_err pulses 1 cycle, no push.
  - While the bit counter is 0, the idle counter holds at 0.
- FIFO:
  - code is driven from the head entry.
  - valid = (fifo_count != 0).
  - pop = valid && ready.
  - A push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Push and pop in the same cycle: count unchanged, both pointers advance; this works when full or when 1 entry.
  - Push and pop in the same cycle on an empty FIFO cannot occur, since pop needs valid.
  - Pointers wrap modulo FIFO_DEPTH.
  - ready while valid=0 has no effect.
  - code and valid are stable while valid=1 and ready=0.
- Overflow:
  - A push refused because the FIFO is full (and no pop that cycle) drops the new code; existing contents are untouched and overflow is set to 1.
  - overflow stays 1 until ovf_clr=1 or reset.
  - If a drop and ovf_clr=1 occur in the same cycle, set wins.
- Receive only: no host-to-device transmit, and the PS/2 lines are never driven.
- Reset mid-frame: the partial frame is discarded, and the next frame is received correctly after the line is idle.
- Glitches: no filtering beyond synchronization; the PS/2 clock is 10-16.7 kHz, far below clk.

Test Plan:
- Frame for 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) with ready=1 -> valid=1 and code=0x1C for 1 cycle, frame_err=0, fifo_count returns to 0.
- Same frame with parity=1 -> frame_err pulses 1 cycle, valid stays 0, fifo_count=0.
- ready=0, send 9 good frames 0x01..0x09 -> fifo_count=8, overflow=1 after the 9th. Then ready=1 pops 0x01..0x08 in order; 0x09 is absent. Pulse ovf_clr -> overflow=0.
- Send 5 bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulse, no push. A following good frame 0xF0 is received as 0xF0.
- FIFO full with ready=1, and the next good frame 0x5A completes in the pop cycle -> fifo_count stays 8, overflow stays 0, 0x5A is popped last.
- Assert rst for 3 cycles mid-frame (after bit 6), then send good frame 0x29 -> outputs 0 during reset, then exactly one code 0x29 and no frame_err.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 pins, deframes
// 11-bit device-to-host frames, checks start/stop/odd parity, and
// queues good scan codes in a FIFO read over valid/ready.
//
//   state    | meaning
//   bit 0    | waiting for start bit (idle, timeout counter held)
//   bit 1-9  | shifting data and parity bits
//   bit 10   | next falling edge carries the stop bit; frame checked
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    code,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          frame_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BIT_IDLE = 4'd0;
  localparam logic [3:0]       BIT_STOP = 4'd10;

  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_dat_s1, r_dat_s2;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_shift;
  logic [TO_W-1:0]  r_idle_cnt;
  logic             r_push_req;
  logic [7:0]       r_push_data;
  logic             r_frame_err;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_fall, w_good, w_pop, w_push_ok, w_drop;

  assign w_fall = r_clk_prev & ~r_clk_s2;
  // Stop bit is the live synced data; r_shift[0] holds start, [9] parity.
  assign w_good = ~r_shift[0] & r_dat_s2 & (^r_shift[9:1]);

  assign valid      = (r_count != '0);
  assign code       = valid ? r_mem[r_rptr] : 8'h00;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

  assign w_pop     = valid & ready;
  assign w_push_ok = r_push_req & ((r_count < DEPTH_C) | w_pop);
  assign w_drop    = r_push_req & ~w_push_ok;

  // Two-flop synchronizers plus edge-detect flop; idle high out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // Frame deserializer, frame check and inactivity timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt   <= BIT_IDLE;
      r_shift     <= '0;
      r_idle_cnt  <= '0;
      r_push_req  <= 1'b0;
      r_push_data <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_push_req  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_idle_cnt <= '0;
        if (r_bit_cnt == BIT_STOP) begin
          r_bit_cnt <= BIT_IDLE;
          if (w_good) begin
            r_push_req  <= 1'b1;
            r_push_data <= r_shift[8:1];
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_shift   <= {r_dat_s2, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt == BIT_IDLE) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt == TO_LAST) begin
        r_bit_cnt   <= BIT_IDLE;
        r_idle_cnt  <= '0;
        r_frame_err <= 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt + TO_W'(1);
      end
    end
  end

  // FIFO storage; contents only observable through the head when valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_push_data;
  end

  // FIFO pointers and occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of single frames plus hand-written
// latency, overflow, timeout, full-with-pop and mid-frame reset sequences.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TOUT  = 5000;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       valid;
  logic       ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic       frame_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_err  = 0;
  logic [7:0] popped [$];

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .valid(valid), .ready(ready), .fifo_count(fifo_count),
    .overflow(overflow), .ovf_clr(ovf_clr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard of everything the consumer accepts, and frame_err cycles.
  always @(negedge clk) begin
    if (valid && ready) popped.push_back(code);
    if (frame_err) n_err++;
  end

  typedef struct {
    logic [7:0] data;
    logic       start;
    logic       par_flip;
    logic       stop;
    logic       good;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic st,
                                           input logic pf, input logic sp);
    return {sp, (~^d) ^ pf, d, st};
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Sends bits 0..9 and drops ps2_clk for the stop bit, leaving it low.
  task automatic send_head(input logic [10:0] f);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = f[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic finish_stop();
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_code", code, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", frame_err, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_err", n_err, 0);

    // Latency of 0x1C: valid one cycle, 2 cycles after the edge is seen.
    ready = 1'b1;
    popped.delete();
    send_head(mk_frame(8'h1C, 1'b0, 1'b0, 1'b1));
    repeat (3) @(negedge clk);
    chk("lat_early_valid", valid, 0);
    @(negedge clk);
    chk("lat_valid", valid, 1);
    chk("lat_code", code, 8'h1C);
    @(negedge clk);
    chk("lat_valid_drop", valid, 0);
    chk("lat_count", fifo_count, 0);
    finish_stop();
    chk("lat_err", n_err, 0);
    chk("lat_npop", popped.size(), 1);

    // Table of single frames with ready=1.
    for (int v = 0; v < 8; v++) begin
      popped.delete();
      n_err = 0;
      send_frame(mk_frame(vecs[v].data, vecs[v].start, vecs[v].par_flip, vecs[v].stop));
      repeat (10) @(negedge clk);
      chk($sformatf("vec%0d_npop", v), popped.size(), vecs[v].good ? 1 : 0);
      chk($sformatf("vec%0d_nerr", v), n_err, vecs[v].good ? 0 : 1);
      chk($sformatf("vec%0d_count", v), fifo_count, 0);
      if (vecs[v].good && popped.size() > 0)
        chk($sformatf("vec%0d_code", v), popped[0], vecs[v].data);
    end

    // Overflow: 9 frames with ready=0, 0x09 dropped.
    ready = 1'b0;
    n_err = 0;
    for (int i = 1; i <= 9; i++) begin
      send_frame(mk_frame(8'(i), 1'b0, 1'b0, 1'b1));
      if (i == 8) begin
        chk("ovf_count8", fifo_count, 8);
        chk("ovf_before", overflow, 0);
      end
    end
    chk("ovf_count9", fifo_count, 8);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", code, 8'h01);
    popped.delete();
    ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("ovf_npop", popped.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < popped.size()) chk($sformatf("ovf_pop%0d", i), popped[i], i + 1);
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", overflow, 0);
    chk("ovf_nerr", n_err, 0);

    // Timeout after 5 bits, then a clean 0xF0.
    popped.delete();
    n_err = 0;
    begin
      logic [10:0] f;
      f = mk_frame(8'hF0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    end
    ps2_data = 1'b1;
    repeat (TOUT - 100) @(negedge clk);
    chk("to_early", n_err, 0);
    repeat (200) @(negedge clk);
    chk("to_err", n_err, 1);
    chk("to_npop", popped.size(), 0);
    chk("to_count", fifo_count, 0);
    send_frame(mk_frame(8'hF0, 1'b0, 1'b0, 1'b1));
    repeat (10) @(negedge clk);
    chk("to_next_npop", popped.size(), 1);
    if (popped.size() > 0) chk("to_next_code", popped[0], 8'hF0);
    chk("to_next_err", n_err, 1);

    // Full FIFO, push of 0x5A lands in a pop cycle.
    ready = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(mk_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b1));
    chk("full_count", fifo_count, 8);
    popped.delete();
    send_head(mk_frame(8'h5A, 1'b0, 1'b0, 1'b1));
    repeat (3) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    chk("full_pp_count", fifo_count, 8);
    chk("full_pp_ovf", overflow, 0);
    finish_stop();
    repeat (10) @(negedge clk);
    chk("full_npop", popped.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < popped.size())
        chk($sformatf("full_pop%0d", i), popped[i], (i < 8) ? 8'h11 + i : 8'h5A);

    // Reset mid-frame, then a clean 0x29.
    ready = 1'b0;
    send_frame(mk_frame(8'h33, 1'b0, 1'b0, 1'b1));
    chk("mr_pre_valid", valid, 1);
    begin
      logic [10:0] f;
      f = mk_frame(8'h29, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) ps2_bit(f[i]);
    end
    ps2_data = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mr_valid%0d", c), valid, 0);
      chk($sformatf("mr_count%0d", c), fifo_count, 0);
      chk($sformatf("mr_code%0d", c), code, 0);
      chk($sformatf("mr_err%0d", c), frame_err, 0);
    end
    rst = 1'b1;
    repeat (50) @(negedge clk);
    popped.delete();
    n_err = 0;
    ready = 1'b1;
    send_frame(mk_frame(8'h29, 1'b0, 1'b0, 1'b1));
    repeat (10) @(negedge clk);
    chk("mr_npop", popped.size(), 1);
    if (popped.size() > 0) chk("mr_code", popped[0], 8'h29);
    chk("mr_nerr", n_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
